mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: a fetch port (read-only, word aligned) and a data
// port (read/write) share one byte-addressed memory with registered read data.
// Data wins by default; fetch is forced through after STARVE_LIMIT denied cycles.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        fetch_req,
    input  logic [4:0]  fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_rvalid,
    output logic [31:0] fetch_rdata,

    input  logic        data_req,
    input  logic        data_we,
    input  logic [4:0]  data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    output logic        data_err,

    output logic        mem_read,
    output logic        mem_write,
    output logic [4:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  starve_cnt;
    owner_t      owner_q;
    owner_t      owner_d;
    logic        err_q;
    logic [31:0] fetch_hold;
    logic [31:0] data_hold;
    logic        fetch_wins;
    logic        data_misaligned;

    // Fetch ignores the byte offset; only the word index reaches memory.
    logic [1:0]  unused_fetch_offset;
    assign unused_fetch_offset = fetch_addr[1:0];

    // Arbitration and memory command; a misaligned data access is granted
    // (so the requester moves on) but never reaches the memory.
    always_comb begin
        fetch_gnt       = 1'b0;
        data_gnt        = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_addr        = 5'd0;
        mem_wdata       = 32'd0;
        owner_d         = OWN_NONE;
        data_misaligned = (data_addr[1:0] != 2'b00);
        fetch_wins      = fetch_req && (!data_req || (starve_cnt == LIMIT));

        if (!rst) begin
            if (fetch_wins) begin
                fetch_gnt = 1'b1;
                mem_read  = 1'b1;
                mem_addr  = {fetch_addr[4:2], 2'b00};
                owner_d   = OWN_FETCH;
            end else if (data_req) begin
                data_gnt = 1'b1;
                if (!data_misaligned) begin
                    mem_addr = data_addr;
                    if (data_we) begin
                        mem_write = 1'b1;
                        mem_wdata = data_wdata;
                    end else begin
                        mem_read = 1'b1;
                        owner_d  = OWN_DATA;
                    end
                end
            end
        end
    end

    // Starvation counter, response owner tag, error pulse and read-data holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
            owner_q    <= OWN_NONE;
            err_q      <= 1'b0;
            fetch_hold <= 32'd0;
            data_hold  <= 32'd0;
        end else begin
            if (fetch_req && !fetch_gnt) begin
                if (starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else begin
                starve_cnt <= 4'd0;
            end
            owner_q <= owner_d;
            err_q   <= data_gnt && data_misaligned;
            if (fetch_rvalid) begin
                fetch_hold <= mem_rdata;
            end
            if (data_rvalid) begin
                data_hold <= mem_rdata;
            end
        end
    end

    // Responses are masked during reset so a read launched just before reset
    // never surfaces.
    assign fetch_rvalid = !rst && (owner_q == OWN_FETCH);
    assign data_rvalid  = !rst && (owner_q == OWN_DATA);
    assign data_err     = !rst && err_q;
    assign fetch_rdata  = fetch_rvalid ? mem_rdata : fetch_hold;
    assign data_rdata   = data_rvalid  ? mem_rdata : data_hold;

endmodule
